// File: rtl/demux8_buf_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : demux8_buf_if                                               |
// | Purpose  : Bundles the input stream, the eight output channels and the |
// |            accepted-word counter of demux8_buf.                        |
// |            master = producer/consumer side, slave = demux8_buf.        |
// | Signals  : in_valid/in_ready/s/d   input stream (one word per cycle)   |
// |            y0..y7/v/r              per-channel head word, valid, take  |
// |            total                   16-bit count of accepted words      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface demux8_buf_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   s;
  logic [N-1:0] d;
  logic [N-1:0] y0;
  logic [N-1:0] y1;
  logic [N-1:0] y2;
  logic [N-1:0] y3;
  logic [N-1:0] y4;
  logic [N-1:0] y5;
  logic [N-1:0] y6;
  logic [N-1:0] y7;
  logic [7:0]   v;
  logic [7:0]   r;
  logic [15:0]  total;

  modport master (
    output in_valid, s, d, r,
    input  in_ready, y0, y1, y2, y3, y4, y5, y6, y7, v, total
  );

  modport slave (
    input  in_valid, s, d, r,
    output in_ready, y0, y1, y2, y3, y4, y5, y6, y7, v, total
  );
endinterface
`default_nettype wire

// File: rtl/demux8_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : demux8_buf                                                  |
// | Purpose  : Buffered 1-to-8 demultiplexer. Each accepted input word is  |
// |            routed by s into a 2-entry FIFO of its channel and held     |
// |            there until that channel's consumer takes it.               |
// | Ports    : clk    rising-edge clock                                    |
// |            reset  synchronous active-high reset                        |
// |            bus    demux8_buf_if.slave: in_valid/in_ready/s/d input,    |
// |                   y0..y7/v/r outputs, total accepted-word counter      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module demux8_buf #(
  parameter int N = 64
) (
  input  wire logic     clk,
  input  wire logic     reset,
  demux8_buf_if.slave   bus
);
  localparam int c_NCH = 8;

  // Per-channel storage and bookkeeping.
  logic [N-1:0]  r_e0 [c_NCH];
  logic [N-1:0]  r_e1 [c_NCH];
  logic [c_NCH-1:0] r_wp;
  logic [c_NCH-1:0] r_rp;
  logic [1:0]    r_cnt [c_NCH];

  // Registered outputs.
  logic [N-1:0]  r_y [c_NCH];
  logic [c_NCH-1:0] r_v;
  logic [15:0]   r_total;

  // Next-state values.
  logic [N-1:0]  w_e0_n [c_NCH];
  logic [N-1:0]  w_e1_n [c_NCH];
  logic [c_NCH-1:0] w_wp_n;
  logic [c_NCH-1:0] w_rp_n;
  logic [1:0]    w_cnt_n [c_NCH];
  logic [N-1:0]  w_y_n [c_NCH];
  logic [c_NCH-1:0] w_v_n;

  logic          w_in_ready;
  logic          w_acc;
  logic [c_NCH-1:0] w_enq;
  logic [c_NCH-1:0] w_deq;

  // Ready depends only on the addressed channel's registered occupancy,
  // never on r: a full channel cannot pass a word through in one cycle.
  assign w_in_ready = (r_cnt[bus.s] != 2'd2);
  assign w_acc      = bus.in_valid & w_in_ready;
  // v mirrors cnt != 0, so r[k] against an empty channel is ignored here.
  assign w_deq      = r_v & bus.r;

  always_comb begin
    for (int k = 0; k < c_NCH; k++) begin
      w_enq[k]   = w_acc && (bus.s == 3'(k));
      w_cnt_n[k] = r_cnt[k] + {1'b0, w_enq[k]} - {1'b0, w_deq[k]};
      w_wp_n[k]  = r_wp[k] ^ w_enq[k];
      w_rp_n[k]  = r_rp[k] ^ w_deq[k];
      w_e0_n[k]  = (w_enq[k] && !r_wp[k]) ? bus.d : r_e0[k];
      w_e1_n[k]  = (w_enq[k] &&  r_wp[k]) ? bus.d : r_e1[k];
      w_v_n[k]   = (w_cnt_n[k] != 2'd0);
      // Head of the FIFO after this edge; forced to zero when empty so y
      // never shows a stale word.
      if (w_cnt_n[k] == 2'd0) begin
        w_y_n[k] = '0;
      end else if (w_rp_n[k]) begin
        w_y_n[k] = w_e1_n[k];
      end else begin
        w_y_n[k] = w_e0_n[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < c_NCH; k++) begin
        r_e0[k]  <= '0;
        r_e1[k]  <= '0;
        r_cnt[k] <= 2'd0;
        r_y[k]   <= '0;
      end
      r_wp    <= '0;
      r_rp    <= '0;
      r_v     <= '0;
      r_total <= 16'd0;
    end else begin
      for (int k = 0; k < c_NCH; k++) begin
        r_e0[k]  <= w_e0_n[k];
        r_e1[k]  <= w_e1_n[k];
        r_cnt[k] <= w_cnt_n[k];
        r_y[k]   <= w_y_n[k];
      end
      r_wp    <= w_wp_n;
      r_rp    <= w_rp_n;
      r_v     <= w_v_n;
      r_total <= r_total + 16'(w_acc);
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.v        = r_v;
  assign bus.total    = r_total;
  assign bus.y0       = r_y[0];
  assign bus.y1       = r_y[1];
  assign bus.y2       = r_y[2];
  assign bus.y3       = r_y[3];
  assign bus.y4       = r_y[4];
  assign bus.y5       = r_y[5];
  assign bus.y6       = r_y[6];
  assign bus.y7       = r_y[7];
endmodule
`default_nettype wire

// File: tb/tb_demux8_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_demux8_buf                                               |
// | Purpose  : Self-checking bench for demux8_buf. A queue-per-channel     |
// |            model predicts in_ready, v, y0..y7 and total.               |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_demux8_buf;
  localparam int N = 64;

  logic clk;
  logic reset;

  demux8_buf_if #(.N(N)) bus ();

  demux8_buf #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one FIFO queue per channel plus an accepted-word count.
  logic [N-1:0] q [8][$];
  int unsigned  m_total;
  bit           known;

  int n_total;
  int n_bad;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] dut_y(input int k);
    case (k)
      0: return bus.y0;
      1: return bus.y1;
      2: return bus.y2;
      3: return bus.y3;
      4: return bus.y4;
      5: return bus.y5;
      6: return bus.y6;
      default: return bus.y7;
    endcase
  endfunction

  task automatic check_outputs();
    logic [7:0]   ev;
    logic [N-1:0] ey;
    for (int k = 0; k < 8; k++) begin
      ev[k] = (q[k].size() != 0);
      ey    = (q[k].size() != 0) ? q[k][0] : '0;
      chk($sformatf("y%0d", k), dut_y(k), ey);
    end
    chk("v", N'(bus.v), N'(ev));
    chk("total", N'(bus.total), N'(m_total % 65536));
  endtask

  // One clock cycle: check in_ready before the edge, advance the model at the
  // edge, then optionally check all outputs just after it.
  task automatic cycle(input bit chk_en);
    bit          acc;
    logic [2:0]  ss;
    logic [N-1:0] dd;
    logic [7:0]  rr;
    @(negedge clk);
    if (known) chk("in_ready", N'(bus.in_ready), N'(q[bus.s].size() != 2));
    ss  = bus.s;
    dd  = bus.d;
    rr  = bus.r;
    acc = bus.in_valid && (q[ss].size() < 2);
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 8; k++) q[k].delete();
      m_total = 0;
      known   = 1'b1;
    end else begin
      for (int k = 0; k < 8; k++)
        if (rr[k] && q[k].size() != 0) void'(q[k].pop_front());
      if (acc) begin
        q[ss].push_back(dd);
        m_total++;
      end
    end
    #1;
    if (chk_en) check_outputs();
  endtask

  task automatic drive(input bit vld, input logic [2:0] ss, input logic [N-1:0] dd);
    bus.in_valid = vld;
    bus.s        = ss;
    bus.d        = dd;
  endtask

  int unsigned base;

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_total = 0;
    known   = 1'b0;

    // Reset held two cycles while an enqueue is offered.
    reset  = 1'b1;
    bus.r  = 8'h00;
    drive(1'b1, 3'd3, 64'd5);
    cycle(1'b1);
    cycle(1'b1);
    reset = 1'b0;
    drive(1'b0, 3'd0, 64'd0);
    chk("rst_v", N'(bus.v), '0);
    chk("rst_total", N'(bus.total), '0);
    for (int k = 0; k < 8; k++) begin
      bus.s = 3'(k);
      cycle(1'b1);
      chk("rdy_after_rst", N'(bus.in_ready), N'(1));
    end

    // Routing: one word to each channel, consumers always ready.
    bus.r = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), 64'(k + 10));
      cycle(1'b1);
      chk("route_y", dut_y(k), 64'(k + 10));
    end
    drive(1'b0, 3'd0, 64'd0);
    cycle(1'b1);
    chk("route_total", N'(bus.total), N'(8));
    chk("route_v_empty", N'(bus.v), '0);

    // Backpressure on channel 2.
    base  = m_total;
    bus.r = 8'hFB;
    drive(1'b1, 3'd2, 64'd7);
    cycle(1'b1);
    drive(1'b1, 3'd2, 64'd8);
    cycle(1'b1);
    drive(1'b1, 3'd2, 64'd9);
    cycle(1'b1);
    chk("bp_ready_low", N'(bus.in_ready), N'(0));
    chk("bp_y2", bus.y2, 64'd7);
    chk("bp_v2", N'(bus.v[2]), N'(1));
    bus.r = 8'hFF;
    cycle(1'b1);
    chk("bp_y2_after_deq", bus.y2, 64'd8);
    chk("bp_ready_back", N'(bus.in_ready), N'(1));
    bus.r = 8'hFB;
    cycle(1'b1);
    chk("bp_total", N'(bus.total), N'((base + 3) % 65536));
    drive(1'b0, 3'd0, 64'd0);
    bus.r = 8'hFF;
    cycle(1'b1);
    chk("bp_y2_nine", bus.y2, 64'd9);
    cycle(1'b1);

    // Simultaneous enqueue and dequeue on channel 5.
    bus.r = 8'hDF;
    drive(1'b1, 3'd5, 64'd20);
    cycle(1'b1);
    base  = m_total;
    bus.r = 8'hFF;
    drive(1'b1, 3'd5, 64'd21);
    cycle(1'b1);
    chk("sim_y5", bus.y5, 64'd21);
    chk("sim_v5", N'(bus.v[5]), N'(1));
    chk("sim_total", N'(bus.total), N'((base + 1) % 65536));
    drive(1'b0, 3'd0, 64'd0);
    cycle(1'b1);

    // Channel 0 full and stalled while channel 6 streams 50 words.
    bus.r = 8'hFE;
    drive(1'b1, 3'd0, 64'd100);
    cycle(1'b1);
    drive(1'b1, 3'd0, 64'd101);
    cycle(1'b1);
    base = m_total;
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 3'd6, 64'(1000 + i));
      cycle(1'b1);
      chk("ind_y6", bus.y6, 64'(1000 + i));
    end
    chk("ind_y0", bus.y0, 64'd100);
    chk("ind_total", N'(bus.total), N'((base + 50) % 65536));
    drive(1'b0, 3'd0, 64'd0);
    bus.r = 8'hFF;
    cycle(1'b1);
    cycle(1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 3'($urandom % 8), {$urandom, $urandom});
      bus.r = 8'($urandom);
      cycle(1'b1);
    end

    // Counter wrap: 65537 accepts from a clean reset.
    reset = 1'b1;
    drive(1'b0, 3'd0, 64'd0);
    cycle(1'b1);
    reset = 1'b0;
    bus.r = 8'hFF;
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 3'($urandom % 8), {$urandom, $urandom});
      cycle((i % 4096) == 0);
    end
    chk("wrap_total", N'(bus.total), N'(1));

    // Reset in mid-stream discards buffered words.
    bus.r = 8'h00;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'(i), 64'(500 + i));
      cycle(1'b1);
    end
    chk("pre_rst_v", N'(bus.v != 8'h00), N'(1));
    reset = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    drive(1'b0, 3'd0, 64'd0);
    chk("mid_rst_v", N'(bus.v), '0);
    chk("mid_rst_total", N'(bus.total), '0);
    bus.r = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      chk("post_rst_v", N'(bus.v), '0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
